axi_burst_master_p: RTL and testbench

Parametrised AXI4 full master that turns single-command requests from local logic into one AXI burst (write or read) at a time. It generalises the fixed 32-bit, counter-generated-data master: configurable data, address and ID widths, externally streamed write data, streamed read data out, legality checks on WRAP and 4 KB boundaries, ID checking and a non-destructive watchdog. It sits between a test/DMA controller and one AXI4 slave port.

---
 rtl/axi_burst_master_p.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_burst_master_p.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_p.sv
// AXI4 master: one local command -> one legality-checked AXI burst; addr valid 2 cycles after accept.
// W is combinational pass-through (1 beat/cycle); stalls come only from the slave or the wdat stream.
module axi_burst_master_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [1:0]            cmd_burst,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [DATA_W-1:0]     wdat_data,
  input  logic [DATA_W/8-1:0]   wdat_strb,
  output logic                  rdat_valid,
  output logic [DATA_W-1:0]     rdat_data,
  output logic                  rdat_last,
  output logic [1:0]            rdat_resp,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [2:0]            done_err,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_W-1:0]       m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_W-1:0]       m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int SIZE = $clog2(DATA_W / 8);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
    logic [ID_W-1:0]   id;
  } cmd_t;

  state_t          state, state_nxt;
  cmd_t            cmd_q;
  logic [8:0]      beat_cnt;
  logic [1:0]      resp_q;
  logic [2:0]      err_q;
  logic [WD_W-1:0] wd_cnt;
  logic [12:0]     burst_bytes, page_end;
  logic            wrap_ok, incr_ok, legal, last_beat, hs, wd_active;

  // A burst ending exactly on the 4 KB line stays inside the page and is legal.
  assign burst_bytes = 13'(({5'd0, cmd_q.len} + 13'd1) << SIZE);
  assign page_end    = {1'b0, cmd_q.addr[11:0]} + burst_bytes;
  assign incr_ok     = (page_end <= 13'd4096);
  assign wrap_ok     = (cmd_q.len inside {8'd1, 8'd3, 8'd7, 8'd15}) &&
                       ((cmd_q.addr[11:0] & (burst_bytes[11:0] - 12'd1)) == 12'd0);
  assign last_beat   = (beat_cnt == {1'b0, cmd_q.len});

  // Reserved burst type 2'b11 is rejected so the AXI side never sees it.
  always_comb begin
    legal = 1'b0;
    case (cmd_q.burst)
      2'b00:   legal = 1'b1;
      2'b01:   legal = incr_ok;
      2'b10:   legal = wrap_ok;
      default: legal = 1'b0;
    endcase
  end

  assign m_axi_awid    = cmd_q.id;
  assign m_axi_awaddr  = cmd_q.addr;
  assign m_axi_awlen   = cmd_q.len;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = cmd_q.burst;
  assign m_axi_arid    = cmd_q.id;
  assign m_axi_araddr  = cmd_q.addr;
  assign m_axi_arlen   = cmd_q.len;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = cmd_q.burst;
  assign m_axi_wdata   = wdat_data;
  assign m_axi_wstrb   = wdat_strb;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wdat_ready    = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rdat_valid    = 1'b0;
    rdat_data     = '0;
    rdat_last     = 1'b0;
    rdat_resp     = 2'b00;
    done_valid    = 1'b0;
    done_resp     = 2'b00;
    done_err      = 3'b000;
    hs            = 1'b0;
    wd_active     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = m_axi_aresetn;
        if (cmd_valid) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = !legal ? S_DONE : (cmd_q.wr ? S_AW : S_AR);
      S_AW: begin
        m_axi_awvalid = 1'b1;
        wd_active     = 1'b1;
        hs            = m_axi_awready;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = wdat_valid;
        wdat_ready   = m_axi_wready;
        m_axi_wlast  = last_beat;
        wd_active    = 1'b1;
        hs           = wdat_valid && m_axi_wready;
        if (hs && last_beat) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        wd_active    = 1'b1;
        hs           = m_axi_bvalid;
        if (m_axi_bvalid) state_nxt = S_DONE;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        wd_active     = 1'b1;
        hs            = m_axi_arready;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        wd_active    = 1'b1;
        hs           = m_axi_rvalid;
        rdat_valid   = m_axi_rvalid;
        if (m_axi_rvalid) begin
          rdat_data = m_axi_rdata;
          rdat_last = m_axi_rlast;
          rdat_resp = m_axi_rresp;
          if (m_axi_rlast) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_resp  = resp_q;
        done_err   = err_q;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      cmd_q    <= '0;
      beat_cnt <= '0;
      resp_q   <= 2'b00;
      err_q    <= 3'b000;
      wd_cnt   <= '0;
    end else begin
      // Watchdog only observes; it saturates and never disturbs the handshakes.
      if (wd_active) begin
        if (hs) wd_cnt <= '0;
        else if (wd_cnt != WD_W'(TIMEOUT)) begin
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt == WD_W'(TIMEOUT - 1)) err_q[1] <= 1'b1;
        end
      end
      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_q    <= '{wr: cmd_wr, addr: cmd_addr, len: cmd_len, burst: cmd_burst, id: cmd_id};
          beat_cnt <= '0;
          resp_q   <= 2'b00;
          err_q    <= 3'b000;
          wd_cnt   <= '0;
        end
        S_CHECK: if (!legal) begin
          err_q[0] <= 1'b1;
          resp_q   <= 2'b10;
        end
        S_W: if (wdat_valid && m_axi_wready) beat_cnt <= beat_cnt + 9'd1;
        S_B: if (m_axi_bvalid) begin
          resp_q <= m_axi_bresp;
          if (m_axi_bid != cmd_q.id) err_q[2] <= 1'b1;
        end
        S_R: if (m_axi_rvalid) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (m_axi_rid != cmd_q.id) err_q[2] <= 1'b1;
          if (m_axi_rlast && !last_beat) resp_q <= 2'b10;
          else if (m_axi_rresp > resp_q) resp_q <= m_axi_rresp;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_master_p.sv
// Directed bench: command table run against a scripted AXI slave, plus a mid-burst reset sequence.
module tb_axi_burst_master_p;
  localparam int DATA_W = 32, ADDR_W = 32, ID_W = 4, TIMEOUT = 16;

  logic m_axi_aclk = 1'b0;
  always #5 m_axi_aclk = ~m_axi_aclk;

  logic m_axi_aresetn;
  logic cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [1:0] cmd_burst;
  logic [ID_W-1:0] cmd_id;
  logic wdat_valid, wdat_ready;
  logic [DATA_W-1:0] wdat_data;
  logic [DATA_W/8-1:0] wdat_strb;
  logic rdat_valid, rdat_last;
  logic [DATA_W-1:0] rdat_data;
  logic [1:0] rdat_resp;
  logic done_valid;
  logic [1:0] done_resp;
  logic [2:0] done_err;
  logic [ID_W-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data), .wdat_strb(wdat_strb),
    .rdat_valid(rdat_valid), .rdat_data(rdat_data), .rdat_last(rdat_last), .rdat_resp(rdat_resp),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    int          dly;       // cycles the slave holds addr-ready low
    int          nb;        // read beats the slave returns
    logic [3:0]  rsp_id;
    logic [1:0]  bresp;
    logic [31:0] rpat;      // rresp of beat i at bits [2i+1:2i]
    logic        legal;
    logic [1:0]  exp_resp;
    logic [2:0]  exp_err;
    int          exp_cyc;   // cycles from acceptance to done_valid
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0, n_fail = 0;

  int r_cyc, r_aw, r_ar, r_w, r_r, r_proto, r_first;
  logic r_done, r_rdy, r_abort;
  logic [1:0] r_resp;
  logic [2:0] r_err;
  logic [31:0] r_addr;
  logic [7:0] r_len, r_vsum;
  logic [1:0] r_burst;
  logic [2:0] r_size;
  logic [3:0] r_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id, input int dly, input int nb,
                              input logic [3:0] rsp_id, input logic [1:0] bresp, input logic [31:0] rpat,
                              input logic legal, input logic [1:0] eresp, input logic [2:0] eerr, input int ecyc);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.id = id;
    v.dly = dly; v.nb = nb; v.rsp_id = rsp_id; v.bresp = bresp; v.rpat = rpat;
    v.legal = legal; v.exp_resp = eresp; v.exp_err = eerr; v.exp_cyc = ecyc;
    vecs.push_back(v);
  endfunction

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_arready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    wdat_valid = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v, input int abort_beat);
    int aw_wait = 0, ar_wait = 0;
    logic aw_pend = 1'b0, ar_pend = 1'b0, w_done = 1'b0, b_done = 1'b0;
    r_cyc = 0; r_aw = 0; r_ar = 0; r_w = 0; r_r = 0; r_proto = 0; r_first = 0;
    r_done = 1'b0; r_abort = 1'b0; r_resp = 2'b00; r_err = 3'b000; r_vsum = 8'hFF;
    r_addr = '0; r_len = '0; r_burst = '0; r_size = '0; r_id = '0;
    @(negedge m_axi_aclk);
    cmd_wr = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_burst = v.burst; cmd_id = v.id;
    cmd_valid = 1'b1;
    #1 r_rdy = cmd_ready;
    @(negedge m_axi_aclk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 300 && !r_done && !r_abort; c++) begin
      m_axi_awready = (aw_wait >= v.dly);
      m_axi_arready = (ar_wait >= v.dly);
      m_axi_wready  = 1'b1;
      wdat_valid    = 1'b1;
      wdat_data     = 32'(r_w + 1) * 32'h11;
      wdat_strb     = 4'hF;
      m_axi_bvalid  = w_done && (r_aw > 0) && !b_done;
      m_axi_bid     = v.rsp_id;
      m_axi_bresp   = v.bresp;
      m_axi_rvalid  = (r_ar > 0) && (r_r < v.nb);
      m_axi_rdata   = 32'hA0 + 32'(r_r);
      m_axi_rresp   = v.rpat[2*r_r +: 2];
      m_axi_rlast   = (r_r == v.nb - 1);
      m_axi_rid     = v.rsp_id;
      #1;
      if (abort_beat >= 0 && m_axi_wvalid && r_w == abort_beat) begin
        m_axi_aresetn = 1'b0;
        #1;
        r_abort = 1'b1;
        r_vsum = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                  m_axi_rready, wdat_ready, done_valid, cmd_ready};
      end else begin
        if ((m_axi_awvalid || m_axi_arvalid) && r_first == 0) r_first = c;
        if (m_axi_awvalid) begin
          if (aw_pend && (m_axi_awaddr !== v.addr || m_axi_awlen !== v.len)) r_proto++;
          if (m_axi_awready) begin
            r_aw++; aw_pend = 1'b0;
            r_addr = m_axi_awaddr; r_len = m_axi_awlen; r_burst = m_axi_awburst;
            r_size = m_axi_awsize; r_id = m_axi_awid;
          end else begin aw_wait++; aw_pend = 1'b1; end
        end else if (aw_pend) r_proto++;
        if (m_axi_arvalid) begin
          if (ar_pend && (m_axi_araddr !== v.addr || m_axi_arlen !== v.len)) r_proto++;
          if (m_axi_arready) begin
            r_ar++; ar_pend = 1'b0;
            r_addr = m_axi_araddr; r_len = m_axi_arlen; r_burst = m_axi_arburst;
            r_size = m_axi_arsize; r_id = m_axi_arid;
          end else begin ar_wait++; ar_pend = 1'b1; end
        end else if (ar_pend) r_proto++;
        if (m_axi_wvalid && r_aw == 0) r_proto++;
        if (m_axi_wvalid && wdat_ready) begin
          if (m_axi_wdata !== wdat_data || m_axi_wstrb !== 4'hF) r_proto++;
          if (m_axi_wlast !== (r_w == int'(v.len))) r_proto++;
          if (m_axi_wlast) w_done = 1'b1;
          r_w++;
        end
        if (m_axi_bvalid && m_axi_bready) b_done = 1'b1;
        if (rdat_valid !== (m_axi_rvalid && m_axi_rready)) r_proto++;
        if (m_axi_rvalid && m_axi_rready) begin
          if (rdat_data !== m_axi_rdata || rdat_last !== m_axi_rlast || rdat_resp !== m_axi_rresp) r_proto++;
          r_r++;
        end
        if (done_valid) begin
          r_done = 1'b1; r_cyc = c; r_resp = done_resp; r_err = done_err;
        end
      end
      @(negedge m_axi_aclk);
    end
    slave_idle();
  endtask

  task automatic check_vec(input vec_t v);
    int exp_beats;
    exp_beats = !v.legal ? 0 : (v.wr ? int'(v.len) + 1 : v.nb);
    run_cmd(v, -1);
    check({v.name, "/cmd_ready"}, r_rdy, 1);
    check({v.name, "/done_seen"}, r_done, 1);
    check({v.name, "/cycles"}, r_cyc, v.exp_cyc);
    check({v.name, "/done_resp"}, r_resp, v.exp_resp);
    check({v.name, "/done_err"}, r_err, v.exp_err);
    check({v.name, "/aw_count"}, r_aw, (v.legal && v.wr) ? 1 : 0);
    check({v.name, "/ar_count"}, r_ar, (v.legal && !v.wr) ? 1 : 0);
    check({v.name, "/beats"}, v.wr ? r_w : r_r, exp_beats);
    check({v.name, "/protocol"}, r_proto, 0);
    if (v.legal) begin
      check({v.name, "/addr_fields"}, {r_addr, r_len, r_burst, r_size, r_id},
            {v.addr, v.len, v.burst, 3'd2, v.id});
      check({v.name, "/addr_latency"}, r_first, 2);
    end
    #1;
    check({v.name, "/done_one_cycle"}, {done_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int pulses;
    m_axi_aresetn = 1'b0;
    cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0; cmd_id = '0;
    wdat_data = '0; wdat_strb = '0; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    slave_idle();
    repeat (2) @(negedge m_axi_aclk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wdat_ready}, 0);
    check("rst_done", {done_valid, done_resp, done_err}, 0);
    check("rst_rdat", {rdat_valid, rdat_last, rdat_resp, rdat_data}, 0);
    m_axi_aresetn = 1'b1;
    #1 check("idle_cmd_ready", cmd_ready, 1);

    //   name            wr addr        len  burst id  dly nb rid bresp rpat   legal resp err     cyc
    add("incr_wr",       1, 32'h100,    3,  2'b01, 1,  0,  4, 1,  0, 32'h0,  1, 2'd0, 3'b000,  8);
    add("wrap_rd",       0, 32'h30,     3,  2'b10, 2,  0,  4, 2,  0, 32'h10, 1, 2'd1, 3'b000,  7);
    add("wrap_len2",     0, 32'h30,     2,  2'b10, 2,  0,  3, 2,  0, 32'h0,  0, 2'd2, 3'b001,  2);
    add("wrap_misalign", 0, 32'h34,     3,  2'b10, 3,  0,  4, 3,  0, 32'h0,  0, 2'd2, 3'b001,  2);
    add("incr_4k_edge",  1, 32'hFF0,    3,  2'b01, 4,  0,  4, 4,  0, 32'h0,  1, 2'd0, 3'b000,  8);
    add("incr_4k_cross", 1, 32'hFF4,    3,  2'b01, 4,  0,  4, 4,  0, 32'h0,  0, 2'd2, 3'b001,  2);
    add("incr_4k_fe0",   1, 32'hFE0,    3,  2'b01, 6,  0,  4, 6,  0, 32'h0,  1, 2'd0, 3'b000,  8);
    add("aw_stall",      1, 32'h400,    1,  2'b01, 0,  20, 2, 0,  0, 32'h0,  1, 2'd0, 3'b010, 26);
    add("bid_err",       1, 32'h500,    0,  2'b01, 5,  0,  1, 3,  2, 32'h0,  1, 2'd2, 3'b100,  5);
    add("fixed_rd_len0", 0, 32'h800,    0,  2'b00, 7,  0,  1, 7,  0, 32'h0,  1, 2'd0, 3'b000,  4);
    add("rid_err",       0, 32'h8,      1,  2'b10, 9,  0,  2, 10, 0, 32'h0,  1, 2'd0, 3'b100,  5);
    add("short_rd",      0, 32'h900,    3,  2'b01, 1,  0,  2, 1,  0, 32'h4,  1, 2'd2, 3'b000,  5);
    add("wrap_wr",       1, 32'h40,     7,  2'b10, 12, 0,  8, 12, 1, 32'h0,  1, 2'd1, 3'b000, 12);
    add("rd_ar_dly",     0, 32'h1000,   1,  2'b01, 2,  3,  2, 2,  0, 32'h4,  1, 2'd1, 3'b000,  8);

    foreach (vecs[i]) check_vec(vecs[i]);

    // Reset while the second beat of an 8-beat write is on the bus.
    begin
      vec_t v;
      v = vecs[0];
      v.name = "rst_mid"; v.addr = 32'h200; v.len = 8'd7; v.nb = 8;
      run_cmd(v, 1);
      check("rst_mid/reached", r_abort, 1);
      check("rst_mid/valids_low", r_vsum, 8'h00);
      check("rst_mid/beats_before", r_w, 1);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge m_axi_aclk);
        if (done_valid) pulses++;
      end
      m_axi_aresetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge m_axi_aclk);
        if (done_valid) pulses++;
      end
      check("rst_mid/no_done", pulses, 0);
      v = vecs[0];
      v.name = "after_rst";
      check_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
